// File: rtl/seq_divider.sv
// seq_divider: iterative radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU.
// One quotient bit per clock; divide-by-zero and signed overflow short-cut
// straight to DONE with the RISC-V defined result.
module seq_divider #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clock_in,
  input  logic                  reset_in,
  input  logic                  start_in,
  input  logic [1:0]            op_in,
  input  logic [DATA_WIDTH-1:0] a_operand_in,
  input  logic [DATA_WIDTH-1:0] b_operand_in,
  output logic                  busy_out,
  output logic                  valid_out,
  output logic [DATA_WIDTH-1:0] result_out
);

  localparam int W  = DATA_WIDTH;
  localparam int CW = $clog2(W + 1);

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  // Per-operation context captured at start.
  typedef struct packed {
    logic is_rem;
    logic neg_q;
    logic neg_r;
  } ctx_t;

  state_t          state, state_nxt;
  ctx_t            ctx;
  logic [W-1:0]    dvd;   // dividend shifts out MSB-first; quotient shifts in at LSB
  logic [W-1:0]    dvs;   // divisor magnitude
  logic [W-1:0]    rem;   // partial remainder
  logic [CW-1:0]   cnt;

  // Request decode (only meaningful in IDLE with start_in)
  logic         signed_op, a_neg, b_neg, div_zero, ovf, corner;
  logic [W-1:0] a_mag, b_mag, corner_res;

  assign signed_op = ~op_in[0];
  assign a_neg     = signed_op & a_operand_in[W-1];
  assign b_neg     = signed_op & b_operand_in[W-1];
  assign div_zero  = (b_operand_in == '0);
  assign ovf       = signed_op & (a_operand_in == {1'b1, {(W-1){1'b0}}})
                               & (b_operand_in == '1);
  assign corner    = div_zero | ovf;
  // Most negative value negates to itself, which is its correct unsigned magnitude.
  assign a_mag     = a_neg ? (~a_operand_in + 1'b1) : a_operand_in;
  assign b_mag     = b_neg ? (~b_operand_in + 1'b1) : b_operand_in;
  // Divide-by-zero wins over overflow (b==0 can never be all ones anyway).
  assign corner_res = op_in[1] ? (div_zero ? a_operand_in : '0)
                               : (div_zero ? '1 : a_operand_in);

  // One restoring step: shift in next dividend bit, subtract if it fits.
  logic [W:0]   partial, diff;
  logic         ge;
  logic [W-1:0] rem_nxt;

  assign partial = {rem, dvd[W-1]};
  assign diff    = partial - {1'b0, dvs};
  assign ge      = (partial >= {1'b0, dvs});
  assign rem_nxt = ge ? diff[W-1:0] : partial[W-1:0];

  // State register.
  always_ff @(posedge clock_in or negedge reset_in) begin
    if (!reset_in) state <= IDLE;
    else           state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (start_in) state_nxt = corner ? DONE : CALC;
      CALC: if (cnt == CW'(1)) state_nxt = FIX;
      FIX:  state_nxt = DONE;
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath: latch request, iterate, and load the final result.
  always_ff @(posedge clock_in or negedge reset_in) begin
    if (!reset_in) begin
      ctx        <= '0;
      dvd        <= '0;
      dvs        <= '0;
      rem        <= '0;
      cnt        <= '0;
      result_out <= '0;
    end else begin
      case (state)
        IDLE: if (start_in) begin
          ctx.is_rem <= op_in[1];
          ctx.neg_q  <= a_neg ^ b_neg;
          ctx.neg_r  <= a_neg;
          dvd        <= a_mag;
          dvs        <= b_mag;
          rem        <= '0;
          cnt        <= CW'(W);
          if (corner) result_out <= corner_res;
        end
        CALC: begin
          dvd <= {dvd[W-2:0], ge};
          rem <= rem_nxt;
          cnt <= cnt - CW'(1);
        end
        FIX: begin
          if (ctx.is_rem) result_out <= ctx.neg_r ? (~rem + 1'b1) : rem;
          else            result_out <= ctx.neg_q ? (~dvd + 1'b1) : dvd;
        end
        default: ;
      endcase
    end
  end

  // Registered status outputs, derived from the state being entered.
  always_ff @(posedge clock_in or negedge reset_in) begin
    if (!reset_in) begin
      busy_out  <= 1'b0;
      valid_out <= 1'b0;
    end else begin
      busy_out  <= (state_nxt != IDLE);
      valid_out <= (state_nxt == DONE);
    end
  end

endmodule

// File: tb/tb_seq_divider.sv
// tb_seq_divider: directed stimulus with a cycle-level reference model and
// literal expectations for the headline vectors.
module tb_seq_divider;

  localparam int W = 32;

  logic          clock_in = 1'b0;
  logic          reset_in = 1'b0;
  logic          start_in = 1'b0;
  logic [1:0]    op_in    = 2'b00;
  logic [W-1:0]  a_operand_in = '0;
  logic [W-1:0]  b_operand_in = '0;
  logic          busy_out, valid_out;
  logic [W-1:0]  result_out;

  seq_divider #(.DATA_WIDTH(W)) dut (
    .clock_in     (clock_in),
    .reset_in     (reset_in),
    .start_in     (start_in),
    .op_in        (op_in),
    .a_operand_in (a_operand_in),
    .b_operand_in (b_operand_in),
    .busy_out     (busy_out),
    .valid_out    (valid_out),
    .result_out   (result_out)
  );

  always #5 clock_in = ~clock_in;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int c0    = 0;
  int vcount = 0;
  logic check_en = 1'b0;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // RISC-V division semantics in plain arithmetic.
  function automatic logic [W-1:0] ref_result(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    logic ov;
    ov = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (op)
      2'd0:    ref_result = (b == 0) ? 32'hFFFF_FFFF : ov ? a : W'($signed(a) / $signed(b));
      2'd1:    ref_result = (b == 0) ? 32'hFFFF_FFFF : a / b;
      2'd2:    ref_result = (b == 0) ? a : ov ? 32'h0 : W'($signed(a) % $signed(b));
      default: ref_result = (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic int ref_latency(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    logic ov;
    ov = !op[0] && (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    ref_latency = ((b == 0) || ov) ? 1 : W + 2;
  endfunction

  // Model: remaining busy cycles and the value result_out should show.
  int           mrem;
  logic [W-1:0] mres, mpend;

  always @(posedge clock_in) cyc <= cyc + 1;

  always @(posedge clock_in or negedge reset_in) begin
    if (!reset_in) begin
      mrem  <= 0;
      mres  <= '0;
      mpend <= '0;
    end else if (mrem > 0) begin
      mrem <= mrem - 1;
      if (mrem == 2) mres <= mpend;
    end else if (start_in) begin
      mrem  <= ref_latency(op_in, a_operand_in, b_operand_in);
      mpend <= ref_result(op_in, a_operand_in, b_operand_in);
      if (ref_latency(op_in, a_operand_in, b_operand_in) == 1)
        mres <= ref_result(op_in, a_operand_in, b_operand_in);
    end
  end

  // Every-cycle comparison against the model.
  always @(negedge clock_in) begin
    if (check_en) begin
      check("busy", W'(busy_out), W'(mrem != 0));
      check("valid", W'(valid_out), W'(mrem == 1));
      check("result", result_out, mres);
      if (valid_out) vcount++;
    end
  end

  task automatic go(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    @(negedge clock_in);
    op_in = op; a_operand_in = a; b_operand_in = b; start_in = 1'b1;
    @(posedge clock_in);
    #1 start_in = 1'b0;
    c0 = cyc;
  endtask

  // Wait for valid (bounded), check result/latency, optionally busy length.
  task automatic wait_done(input string name, input logic [W-1:0] exp, input int exp_lat, input int exp_busy);
    int lat, nbusy;
    bit seen;
    lat = 0; nbusy = 0; seen = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clock_in);
      if (busy_out) nbusy++;
      if (valid_out && !seen) begin
        seen = 1;
        lat  = cyc - c0 + 1;
        check({name, "_res"}, result_out, exp);
      end
      if (!busy_out) break;
    end
    if (!seen) check({name, "_timeout"}, 32'd0, 32'd1);
    else       check({name, "_lat"}, W'(lat), W'(exp_lat));
    if (exp_busy >= 0) check({name, "_busy"}, W'(nbusy), W'(exp_busy));
  endtask

  task automatic run(input string name, input logic [1:0] op, input logic [W-1:0] a,
                     input logic [W-1:0] b, input logic [W-1:0] exp, input int exp_lat);
    go(op, a, b);
    wait_done(name, exp, exp_lat, exp_lat);
  endtask

  initial begin
    int n;
    int v0;
    #1 check_en = 1'b1;
    #2;
    check("rst_busy", W'(busy_out), 32'd0);
    check("rst_valid", W'(valid_out), 32'd0);
    check("rst_result", result_out, 32'd0);
    repeat (2) @(negedge clock_in);
    reset_in = 1'b1;
    repeat (2) @(negedge clock_in);

    run("divu_100_7",  2'd1, 32'd100, 32'd7, 32'd14, 34);
    run("remu_100_7",  2'd3, 32'd100, 32'd7, 32'd2, 34);
    run("div_m7_2",    2'd0, -32'sd7, 32'd2, 32'hFFFF_FFFD, 34);
    run("rem_m7_2",    2'd2, -32'sd7, 32'd2, 32'hFFFF_FFFF, 34);
    run("div_7_m2",    2'd0, 32'd7, -32'sd2, 32'hFFFF_FFFD, 34);
    run("rem_7_m2",    2'd2, 32'd7, -32'sd2, 32'd1, 34);
    run("div_5_0",     2'd0, 32'd5, 32'd0, 32'hFFFF_FFFF, 1);
    run("rem_5_0",     2'd2, 32'd5, 32'd0, 32'd5, 1);
    run("divu_5_0",    2'd1, 32'd5, 32'd0, 32'hFFFF_FFFF, 1);
    run("remu_5_0",    2'd3, 32'd5, 32'd0, 32'd5, 1);
    run("div_ovf",     2'd0, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
    run("rem_ovf",     2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1);
    run("divu_big",    2'd1, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 34);
    run("divu_ff_10",  2'd1, 32'hFFFF_FFFF, 32'h10, 32'h0FFF_FFFF, 34);
    run("remu_ff_10",  2'd3, 32'hFFFF_FFFF, 32'h10, 32'hF, 34);
    run("div_min_2",   2'd0, 32'h8000_0000, 32'd2, 32'hC000_0000, 34);
    run("rem_m9_m4",   2'd2, -32'sd9, -32'sd4, 32'hFFFF_FFFF, 34);
    run("div_m9_m4",   2'd0, -32'sd9, -32'sd4, 32'd2, 34);

    // Start pulsed mid-operation must be ignored.
    v0 = vcount;
    go(2'd1, 32'd100, 32'd7);
    repeat (9) @(negedge clock_in);
    op_in = 2'd1; a_operand_in = 32'd9; b_operand_in = 32'd3; start_in = 1'b1;
    @(posedge clock_in);
    #1 start_in = 1'b0;
    wait_done("ignored_start", 32'd14, 34, -1);
    check("ignored_one_pulse", W'(vcount - v0), 32'd1);
    run("after_ignore", 2'd1, 32'd9, 32'd3, 32'd3, 34);

    // Reset mid-operation.
    go(2'd1, 32'd100, 32'd7);
    repeat (14) @(negedge clock_in);
    @(posedge clock_in);
    #2 reset_in = 1'b0;
    #1;
    check("async_rst_busy", W'(busy_out), 32'd0);
    check("async_rst_valid", W'(valid_out), 32'd0);
    check("async_rst_result", result_out, 32'd0);
    @(negedge clock_in);
    reset_in = 1'b1;
    n = 0;
    repeat (40) begin
      @(negedge clock_in);
      if (valid_out) n++;
    end
    check("no_valid_after_rst", W'(n), 32'd0);
    run("post_rst_divu", 2'd1, 32'd9, 32'd3, 32'd3, 34);

    repeat (2) @(negedge clock_in);
    check_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
